// File: rtl/uart_txn_sequencer.sv
// rtl/uart_txn_sequencer.sv - replays a program of UART transactions and scores the echoed results
module uart_txn_sequencer #(
    parameter int DATA_BITS      = 8,
    parameter int NUM_WORDS      = 3,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_BITS       = 8
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset,
    input  logic                                 i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]             i_wr_addr,
    input  logic [(NUM_WORDS+1)*DATA_BITS-1:0]   i_wr_data,
    input  logic [$clog2(DEPTH):0]               i_num_txn,
    input  logic                                 i_start,
    output logic                                 o_tx_start,
    output logic [DATA_BITS-1:0]                 o_tx_data,
    input  logic                                 i_tx_done,
    input  logic                                 i_rx_done,
    input  logic [DATA_BITS-1:0]                 i_rx_data,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic [CNT_BITS-1:0]                  o_pass_count,
    output logic [CNT_BITS-1:0]                  o_fail_count,
    output logic                                 o_timeout,
    output logic [DATA_BITS-1:0]                 o_last_result
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = (NUM_WORDS + 1) * DATA_BITS;
    localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [AW:0]       DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0]       TXN_ONE   = (AW+1)'(1);
    localparam logic [WW-1:0]     WORD_ONE  = WW'(1);
    localparam logic [WW-1:0]     WORD_LAST = WW'(NUM_WORDS - 1);
    localparam logic [TW-1:0]     TMO_ONE   = TW'(1);
    localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    typedef enum logic [3:0] {
        IDLE, LOAD, SEND, WAIT_TX, WAIT_RX, CHECK, TMO, NEXT, DONE
    } state_t;

    state_t                 state;
    logic [EW-1:0]          mem [DEPTH];
    logic [EW-1:0]          entry_r;
    logic [WW-1:0]          word;
    logic [AW:0]            txn;
    logic [AW:0]            num_r;
    logic [TW-1:0]          tmo_cnt;
    logic [WW-1:0]          word_nxt;
    logic [DATA_BITS-1:0]   next_byte;
    logic [DATA_BITS-1:0]   first_byte;
    logic [DATA_BITS-1:0]   exp_byte;
    logic                   tmo_hit;

    // Program memory has no reset; it only accepts writes while not sequencing.
    always_ff @(posedge i_clock) begin
        if (i_wr_en && (state == IDLE || state == DONE))
            mem[i_wr_addr] <= i_wr_data;
    end

    always_comb begin
        word_nxt  = word + WORD_ONE;
        next_byte = '0;
        for (int k = 0; k < NUM_WORDS; k++)
            if (word_nxt == WW'(k))
                next_byte = entry_r[k*DATA_BITS +: DATA_BITS];
        first_byte = mem[txn[AW-1:0]][DATA_BITS-1:0];
        exp_byte   = entry_r[NUM_WORDS*DATA_BITS +: DATA_BITS];
        tmo_hit    = (tmo_cnt == TMO_LAST);
    end

    // o_tx_start is set on the edge entering SEND so the pulse coincides with that state.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state         <= IDLE;
            entry_r       <= '0;
            word          <= '0;
            txn           <= '0;
            num_r         <= '0;
            tmo_cnt       <= '0;
            o_tx_start    <= 1'b0;
            o_tx_data     <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_pass_count  <= '0;
            o_fail_count  <= '0;
            o_timeout     <= 1'b0;
            o_last_result <= '0;
        end else begin
            o_tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        num_r         <= (i_num_txn > DEPTH_C) ? DEPTH_C : i_num_txn;
                        txn           <= '0;
                        o_pass_count  <= '0;
                        o_fail_count  <= '0;
                        o_timeout     <= 1'b0;
                        o_last_result <= '0;
                        if (i_num_txn == '0) begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            o_done <= 1'b0;
                            o_busy <= 1'b1;
                            state  <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    entry_r    <= mem[txn[AW-1:0]];
                    word       <= '0;
                    o_tx_start <= 1'b1;
                    o_tx_data  <= first_byte;
                    state      <= SEND;
                end
                SEND: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        if (word != WORD_LAST) begin
                            word       <= word_nxt;
                            o_tx_start <= 1'b1;
                            o_tx_data  <= next_byte;
                            state      <= SEND;
                        end else begin
                            tmo_cnt <= '0;
                            state   <= WAIT_RX;
                        end
                    end else if (tmo_hit) begin
                        state <= TMO;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                    end
                end
                WAIT_RX: begin
                    if (i_rx_done) begin
                        o_last_result <= i_rx_data;
                        state         <= CHECK;
                    end else if (tmo_hit) begin
                        state <= TMO;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                    end
                end
                CHECK: begin
                    if (o_last_result == exp_byte) begin
                        if (o_pass_count != '1) o_pass_count <= o_pass_count + CNT_ONE;
                    end else begin
                        if (o_fail_count != '1) o_fail_count <= o_fail_count + CNT_ONE;
                    end
                    state <= NEXT;
                end
                TMO: begin
                    if (o_fail_count != '1) o_fail_count <= o_fail_count + CNT_ONE;
                    o_timeout <= 1'b1;
                    state     <= NEXT;
                end
                NEXT: begin
                    txn <= txn + TXN_ONE;
                    if (txn + TXN_ONE == num_r) begin
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= LOAD;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_txn_sequencer.sv
// tb/tb_uart_txn_sequencer.sv - scoreboard bench for uart_txn_sequencer
module tb_uart_txn_sequencer;

    localparam int DB  = 8;
    localparam int NW  = 3;
    localparam int DEP = 16;
    localparam int TMO = 50;
    localparam int CB  = 8;

    logic                 i_clock = 1'b0;
    logic                 i_reset = 1'b0;
    logic                 i_wr_en = 1'b0;
    logic [3:0]           i_wr_addr = '0;
    logic [(NW+1)*DB-1:0] i_wr_data = '0;
    logic [4:0]           i_num_txn = '0;
    logic                 i_start = 1'b0;
    logic                 o_tx_start;
    logic [DB-1:0]        o_tx_data;
    logic                 i_tx_done = 1'b0;
    logic                 i_rx_done = 1'b0;
    logic [DB-1:0]        i_rx_data = '0;
    logic                 o_busy;
    logic                 o_done;
    logic [CB-1:0]        o_pass_count;
    logic [CB-1:0]        o_fail_count;
    logic                 o_timeout;
    logic [DB-1:0]        o_last_result;

    always #5 i_clock = ~i_clock;

    uart_txn_sequencer #(
        .DATA_BITS(DB), .NUM_WORDS(NW), .DEPTH(DEP), .TIMEOUT_CYCLES(TMO), .CNT_BITS(CB)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .i_num_txn(i_num_txn), .i_start(i_start),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_done(i_tx_done),
        .i_rx_done(i_rx_done), .i_rx_data(i_rx_data), .o_busy(o_busy), .o_done(o_done),
        .o_pass_count(o_pass_count), .o_fail_count(o_fail_count), .o_timeout(o_timeout),
        .o_last_result(o_last_result)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_tx  = 0;
    int          cycle = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;

    always @(posedge i_clock) cycle <= cycle + 1;

    // Scoreboard: every transmitted byte must match the next queued expectation.
    always @(negedge i_clock) begin
        if (o_tx_start) begin
            n_tx  = n_tx + 1;
            n_cmp = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL tx_byte: unexpected o_tx_start, data=%0d", o_tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (o_tx_data !== mon_exp) begin
                    n_err = n_err + 1;
                    $display("FAIL tx_byte: got %0d expected %0d", o_tx_data, mon_exp);
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge i_clock);
    endtask

    task automatic write_entry(input logic [3:0] addr, input logic [7:0] a, b, op, e);
        i_wr_en = 1'b1; i_wr_addr = addr; i_wr_data = {e, op, b, a};
        cyc();
        i_wr_en = 1'b0;
    endtask

    task automatic push_txn(input logic [7:0] a, b, op);
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(op);
    endtask

    task automatic start_seq(input logic [4:0] n);
        i_num_txn = n; i_start = 1'b1;
        cyc();
        i_start = 1'b0;
    endtask

    task automatic wait_tx(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (o_tx_start) begin ok = 1'b1; break; end
            cyc();
        end
        if (!ok) begin
            n_cmp = n_cmp + 1; n_err = n_err + 1;
            $display("FAIL wait_tx: no o_tx_start within 300 cycles");
        end
    endtask

    task automatic serve_byte();
        bit ok;
        wait_tx(ok);
        if (ok) begin
            cyc(9);
            i_tx_done = 1'b1;
            cyc();
            i_tx_done = 1'b0;
        end
    endtask

    task automatic serve_txn(input logic [7:0] rx);
        repeat (3) serve_byte();
        cyc(3);
        i_rx_done = 1'b1; i_rx_data = rx;
        cyc();
        i_rx_done = 1'b0;
    endtask

    task automatic wait_done(output bit busy_fell);
        bit ok = 1'b0;
        bit prev_busy = o_busy;
        busy_fell = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (o_done) begin ok = 1'b1; busy_fell = prev_busy && !o_busy; break; end
            prev_busy = o_busy;
            cyc();
        end
        if (!ok) begin
            n_cmp = n_cmp + 1; n_err = n_err + 1;
            $display("FAIL wait_done: o_done not seen within 400 cycles");
        end
        cyc();
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        cyc(2);
        n_cmp = n_cmp + 1;
        if ({o_tx_start, o_tx_data, o_busy, o_done, o_pass_count, o_fail_count, o_timeout, o_last_result} !== '0) begin
            n_err = n_err + 1;
            $display("FAIL reset_outputs: busy=%b done=%b pass=%0d fail=%0d expected all zero", o_busy, o_done, o_pass_count, o_fail_count);
        end
        i_reset = 1'b1;
        cyc();
    endtask

    task automatic test_single_pass();
        int t0;
        bit bf;
        write_entry(4'd0, 8'd22, 8'd18, 8'h20, 8'd40);
        push_txn(8'd22, 8'd18, 8'h20);
        t0 = n_tx;
        start_seq(5'd1);
        serve_txn(8'd40);
        wait_done(bf);
        n_cmp = n_cmp + 1;
        if (n_tx - t0 !== 3) begin n_err = n_err + 1; $display("FAIL pass_txcount: got %0d expected 3", n_tx - t0); end
        n_cmp = n_cmp + 1;
        if (o_pass_count !== 8'd1 || o_fail_count !== 8'd0) begin
            n_err = n_err + 1; $display("FAIL pass_counts: pass=%0d fail=%0d expected 1/0", o_pass_count, o_fail_count);
        end
        n_cmp = n_cmp + 1;
        if (o_done !== 1'b1 || o_last_result !== 8'd40) begin
            n_err = n_err + 1; $display("FAIL pass_done_last: done=%b last=%0d expected 1/40", o_done, o_last_result);
        end
    endtask

    task automatic test_single_fail();
        bit bf;
        push_txn(8'd22, 8'd18, 8'h20);
        start_seq(5'd1);
        serve_txn(8'd41);
        wait_done(bf);
        n_cmp = n_cmp + 1;
        if (o_pass_count !== 8'd0 || o_fail_count !== 8'd1) begin
            n_err = n_err + 1; $display("FAIL fail_counts: pass=%0d fail=%0d expected 0/1", o_pass_count, o_fail_count);
        end
        n_cmp = n_cmp + 1;
        if (o_last_result !== 8'd41 || o_timeout !== 1'b0) begin
            n_err = n_err + 1; $display("FAIL fail_last_tmo: last=%0d timeout=%b expected 41/0", o_last_result, o_timeout);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a[3], b[3], op[3], e[3], rx[3];
        int exp_pass = 0, exp_fail = 0, t0;
        bit bf;
        a  = '{8'd22, 8'd5,  8'd9};
        b  = '{8'd18, 8'd7,  8'd3};
        op = '{8'h20, 8'h01, 8'h02};
        e  = '{8'd40, 8'd12, 8'd6};
        rx = '{8'd40, 8'd99, 8'd6};
        for (int i = 0; i < 3; i++) begin
            write_entry(4'(i), a[i], b[i], op[i], e[i]);
            push_txn(a[i], b[i], op[i]);
            if (rx[i] == e[i]) exp_pass++; else exp_fail++;
        end
        t0 = n_tx;
        start_seq(5'd3);
        for (int i = 0; i < 3; i++) serve_txn(rx[i]);
        wait_done(bf);
        n_cmp = n_cmp + 1;
        if (n_tx - t0 !== 9) begin n_err = n_err + 1; $display("FAIL multi_txcount: got %0d expected 9", n_tx - t0); end
        n_cmp = n_cmp + 1;
        if (o_pass_count !== 8'(exp_pass) || o_fail_count !== 8'(exp_fail)) begin
            n_err = n_err + 1; $display("FAIL multi_counts: pass=%0d fail=%0d expected %0d/%0d", o_pass_count, o_fail_count, exp_pass, exp_fail);
        end
        n_cmp = n_cmp + 1;
        if (bf !== 1'b1) begin n_err = n_err + 1; $display("FAIL multi_busy_edge: busy_fell_with_done=%b expected 1", bf); end
    endtask

    task automatic test_timeout();
        int t0, c0, c1;
        bit ok, bf;
        exp_q.push_back(8'd22);
        push_txn(8'd5, 8'd7, 8'h01);
        t0 = n_tx;
        start_seq(5'd2);
        wait_tx(ok);
        c0 = cycle;
        cyc();
        wait_tx(ok);
        c1 = cycle;
        n_cmp = n_cmp + 1;
        if (c1 - c0 !== TMO + 4) begin
            n_err = n_err + 1; $display("FAIL tmo_gap: send-to-send %0d cycles expected %0d", c1 - c0, TMO + 4);
        end
        serve_txn(8'd12);
        wait_done(bf);
        n_cmp = n_cmp + 1;
        if (n_tx - t0 !== 4) begin n_err = n_err + 1; $display("FAIL tmo_txcount: got %0d expected 4", n_tx - t0); end
        n_cmp = n_cmp + 1;
        if (o_timeout !== 1'b1 || o_fail_count !== 8'd1 || o_pass_count !== 8'd1) begin
            n_err = n_err + 1; $display("FAIL tmo_status: timeout=%b fail=%0d pass=%0d expected 1/1/1", o_timeout, o_fail_count, o_pass_count);
        end
    endtask

    task automatic test_zero_txn();
        int t0;
        bit seen = 1'b0;
        t0 = n_tx;
        start_seq(5'd0);
        for (int i = 0; i < 2; i++) begin
            if (o_done) begin seen = 1'b1; break; end
            cyc();
        end
        n_cmp = n_cmp + 1;
        if (!seen) begin n_err = n_err + 1; $display("FAIL zero_done: o_done=%b expected 1 within 2 cycles", o_done); end
        cyc(2);
        n_cmp = n_cmp + 1;
        if (n_tx - t0 !== 0 || o_pass_count !== 8'd0 || o_fail_count !== 8'd0 || o_timeout !== 1'b0 || o_busy !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL zero_state: tx=%0d pass=%0d fail=%0d tmo=%b busy=%b expected 0/0/0/0/0", n_tx - t0, o_pass_count, o_fail_count, o_timeout, o_busy);
        end
    endtask

    task automatic test_stray_and_reset();
        bit ok, bf;
        write_entry(4'd0, 8'd1, 8'd2, 8'd3, 8'd4);
        push_txn(8'd1, 8'd2, 8'd3);
        start_seq(5'd1);
        wait_tx(ok);
        cyc(2);
        i_rx_done = 1'b1; i_rx_data = 8'h55;
        cyc();
        i_rx_done = 1'b0;
        n_cmp = n_cmp + 1;
        if (o_last_result !== 8'd0) begin n_err = n_err + 1; $display("FAIL stray_rx: last=%0d expected 0", o_last_result); end
        i_num_txn = 5'd5; i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        cyc(4);
        i_tx_done = 1'b1;
        cyc();
        i_tx_done = 1'b0;
        n_cmp = n_cmp + 1;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            n_err = n_err + 1; $display("FAIL busy_start: busy=%b done=%b expected 1/0", o_busy, o_done);
        end
        serve_byte();
        serve_byte();
        cyc(3);
        i_reset = 1'b0;
        #2;
        n_cmp = n_cmp + 1;
        if ({o_tx_start, o_tx_data, o_busy, o_done, o_pass_count, o_fail_count, o_timeout, o_last_result} !== '0) begin
            n_err = n_err + 1; $display("FAIL async_reset: busy=%b done=%b data=%0d expected all zero", o_busy, o_done, o_tx_data);
        end
        cyc(2);
        i_reset = 1'b1;
        cyc();
        n_cmp = n_cmp + 1;
        if (exp_q.size() !== 0 || o_busy !== 1'b0) begin
            n_err = n_err + 1; $display("FAIL after_reset: pending=%0d busy=%b expected 0/0", exp_q.size(), o_busy);
        end
        write_entry(4'd0, 8'd1, 8'd2, 8'd3, 8'd4);
        push_txn(8'd1, 8'd2, 8'd3);
        start_seq(5'd1);
        serve_txn(8'd4);
        wait_done(bf);
        n_cmp = n_cmp + 1;
        if (o_pass_count !== 8'd1 || o_fail_count !== 8'd0 || o_done !== 1'b1 || o_last_result !== 8'd4) begin
            n_err = n_err + 1;
            $display("FAIL fresh_run: pass=%0d fail=%0d done=%b last=%0d expected 1/0/1/4", o_pass_count, o_fail_count, o_done, o_last_result);
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_single_fail();
        test_back_to_back();
        test_timeout();
        test_zero_txn();
        test_stray_and_reset();
        cyc(2);
        n_cmp = n_cmp + 1;
        if (exp_q.size() !== 0) begin n_err = n_err + 1; $display("FAIL scoreboard_drain: %0d bytes never sent, expected 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
